servo_cmd_avalon_master: RTL and testbench

SERVO_CMD_AVALON_MASTER -- requirements
Module: servo_cmd_avalon_master

---
 rtl/servo_cmd_avalon_master.sv | 234 +++++++++++++++++++++++
 tb/tb_servo_cmd_avalon_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_cmd_avalon_master.sv
`default_nettype none
// ============================================================================
// Module      : servo_cmd_avalon_master
// Description : Queues servo lock/unlock commands and issues each one as an
//               Avalon-MM write of 8'h01 (lock) or 8'h00 (unlock) to the servo
//               lock register. Waitrequest stalls are bounded by a timeout.
//               Optional macro SERVO_CMD_READBACK_EN adds a read-back of the
//               register after each write and verifies bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_cmd_avalon_master #(
    parameter int ADDR_W         = 4,
    parameter int SERVO_ADDR     = 0,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    input  logic              cmd_lock,
    output logic              cmd_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [7:0]        avm_writedata,
    input  logic              avm_waitrequest,
    output logic              avm_read,
    input  logic [7:0]        avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = 1;
    localparam logic [c_TMR_W-1:0] c_TMR_ONE    = 1;
    localparam logic [c_TMR_W-1:0] c_TIMEOUT    = c_TMR_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_W-1:0]  c_SERVO_ADDR = ADDR_W'(SERVO_ADDR);

    // READ/CHECK only exist when the read-back path is built in
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
`ifdef SERVO_CMD_READBACK_EN
        ST_READ  = 3'd3,
        ST_CHECK = 3'd4,
`endif
        ST_RESP  = 3'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  count_q, count_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
    logic [7:0]          avm_writedata_q, avm_writedata_d;
    logic                avm_write_q, avm_write_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [c_TMR_W-1:0]  timer_q, timer_d;
    logic [c_TMR_W-1:0]  w_timer_inc;
    logic                w_push;
    logic                w_pop;
`ifdef SERVO_CMD_READBACK_EN
    logic                avm_read_q, avm_read_d;
    logic                rd_bit_q, rd_bit_d;
`endif

    // Only bit 0 of the read data is meaningful, and only with read-back
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;

    // Next-state logic for the transfer FSM and the command FIFO
    always_comb begin
        state_d         = state_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        avm_write_d     = avm_write_q;
        timer_d         = timer_q;
        done_d          = 1'b0;
        error_d         = 1'b0;
        w_pop           = 1'b0;
        w_timer_inc     = timer_q + c_TMR_ONE;
        // cmd_ready_q reflects the registered fill level, so a pop in this
        // cycle never opens a slot for a push into a full queue
        w_push          = cmd_valid && cmd_ready_q;
`ifdef SERVO_CMD_READBACK_EN
        avm_read_d      = avm_read_q;
        rd_bit_d        = rd_bit_q;
`endif

        case (state_q)
            // RESP also launches the next queued command so back-to-back
            // transfers are separated by exactly one idle bus cycle
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (count_q != '0) begin
                    w_pop           = 1'b1;
                    avm_address_d   = c_SERVO_ADDR;
                    avm_writedata_d = {7'b0, mem_q[rd_ptr_q]};
                    avm_write_d     = 1'b1;
                    timer_d         = '0;
                    state_d         = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
                    avm_write_d = 1'b0;
                    timer_d     = '0;
`ifdef SERVO_CMD_READBACK_EN
                    avm_read_d  = 1'b1;
                    state_d     = ST_READ;
`else
                    done_d      = 1'b1;
                    state_d     = ST_RESP;
`endif
                end else if (w_timer_inc == c_TIMEOUT) begin
                    avm_write_d = 1'b0;
                    error_d     = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d     = w_timer_inc;
                end
            end
`ifdef SERVO_CMD_READBACK_EN
            ST_READ: begin
                if (!avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    rd_bit_d   = avm_readdata[0];
                    timer_d    = '0;
                    state_d    = ST_CHECK;
                end else if (w_timer_inc == c_TIMEOUT) begin
                    avm_read_d = 1'b0;
                    error_d    = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d    = w_timer_inc;
                end
            end
            ST_CHECK: begin
                // The written data still holds the commanded lock bit
                if (rd_bit_q == avm_writedata_q[0]) begin
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = cmd_lock;
            wr_ptr_d        = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        count_d     = count_q + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};
        cmd_ready_d = (count_d != c_DEPTH);
        busy_d      = (state_d != ST_IDLE) || (count_d != '0);
    end

    // State and registered outputs; reset clears the queue and drops the bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            mem_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            cmd_ready_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_write_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            timer_q         <= '0;
`ifdef SERVO_CMD_READBACK_EN
            avm_read_q      <= 1'b0;
            rd_bit_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            mem_q           <= mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            cmd_ready_q     <= cmd_ready_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            avm_write_q     <= avm_write_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            timer_q         <= timer_d;
`ifdef SERVO_CMD_READBACK_EN
            avm_read_q      <= avm_read_d;
            rd_bit_q        <= rd_bit_d;
`endif
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign avm_address   = avm_address_q;
    assign avm_writedata = avm_writedata_q;
    assign avm_write     = avm_write_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
`ifdef SERVO_CMD_READBACK_EN
    assign avm_read      = avm_read_q;
`else
    assign avm_read      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_servo_cmd_avalon_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_cmd_avalon_master
// Description : Scoreboard bench for servo_cmd_avalon_master. Stimulus pushes
//               expected bus/status events; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_cmd_avalon_master;

    localparam int c_TIMEOUT = 8;

    localparam logic [1:0] c_EV_WR   = 2'd0;
    localparam logic [1:0] c_EV_RD   = 2'd1;
    localparam logic [1:0] c_EV_DONE = 2'd2;
    localparam logic [1:0] c_EV_ERR  = 2'd3;

    localparam int c_K_NORMAL   = 0;
    localparam int c_K_TIMEOUT  = 1;
    localparam int c_K_NONE     = 2;
    localparam int c_K_MISMATCH = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_lock;
    logic       cmd_ready;
    logic [3:0] avm_address;
    logic       avm_write;
    logic [7:0] avm_writedata;
    logic       avm_waitrequest;
    logic       avm_read;
    logic [7:0] avm_readdata;
    logic       busy;
    logic       done;
    logic       error;

    logic r_slave_bit = 1'b0;
    logic r_force_en;
    logic r_force_val;

    int vectors     = 0;
    int miscompares = 0;
    logic [13:0] exp_q[$];

    int   run_len      = 0;
    int   last_run_len = 0;
    int   gap          = 999;
    int   last_gap     = 999;
    logic prev_write   = 1'b0;
    logic [11:0] prev_aw = '0;

    servo_cmd_avalon_master #(
        .ADDR_W        (4),
        .SERVO_ADDR    (0),
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(c_TIMEOUT)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_lock       (cmd_lock),
        .cmd_ready      (cmd_ready),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    // Slave register model: remembers the last accepted write for read-back
    always @(posedge clk) begin
        if (avm_write && !avm_waitrequest) r_slave_bit <= avm_writedata[0];
    end
    assign avm_readdata = {7'b0, r_force_en ? r_force_val : r_slave_bit};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic sb_compare(input string name, input logic [13:0] obs);
        logic [13:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected event %h, scoreboard empty", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (e !== obs) begin
                miscompares++;
                $display("FAIL %s: actual event %h, required %h", name, obs, e);
            end
        end
    endtask

    function automatic logic [13:0] ev_wr(input logic lock);
        return {c_EV_WR, 4'h0, 7'b0, lock};
    endfunction

    // Monitor: turns DUT activity into events and checks bus invariants
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                run_len    = 0;
                gap        = 999;
                prev_write = 1'b0;
            end else begin
                if (avm_write && !avm_waitrequest)
                    sb_compare("bus_write", {c_EV_WR, avm_address, avm_writedata});
                if (avm_read && !avm_waitrequest)
                    sb_compare("bus_read", {c_EV_RD, avm_address, 8'h00});
                if (done)  sb_compare("done_pulse",  {c_EV_DONE, 12'h000});
                if (error) sb_compare("error_pulse", {c_EV_ERR,  12'h000});
                if (done && error) begin
                    miscompares++;
                    $display("FAIL done_error_overlap: actual both 1, required not both");
                end
                if (avm_write && avm_read) begin
                    miscompares++;
                    $display("FAIL write_read_overlap: actual both 1, required not both");
                end
`ifndef SERVO_CMD_READBACK_EN
                if (avm_read) begin
                    miscompares++;
                    $display("FAIL read_tied_low: actual avm_read 1, required 0");
                end
`endif
                if (avm_write && prev_write && ({avm_address, avm_writedata} != prev_aw)) begin
                    miscompares++;
                    $display("FAIL write_stable: actual %h, required %h", {avm_address, avm_writedata}, prev_aw);
                end
                if (avm_write) begin
                    if (!prev_write) begin
                        last_gap = gap;
                        run_len  = 1;
                    end else begin
                        run_len++;
                    end
                    prev_aw = {avm_address, avm_writedata};
                end else begin
                    if (prev_write) begin
                        last_run_len = run_len;
                        gap          = 1;
                    end else begin
                        gap++;
                    end
                end
                prev_write = avm_write;
            end
        end
    end

    // Present one command; returns one time step after the accepting edge
    task automatic push_cmd(input logic lock, input int kind);
        bit rdy;
        bit accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_lock  = lock;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("FAIL push_accept: actual not accepted, required accepted");
        end else begin
            case (kind)
                c_K_NORMAL: begin
                    exp_q.push_back(ev_wr(lock));
`ifdef SERVO_CMD_READBACK_EN
                    exp_q.push_back({c_EV_RD, 12'h000});
`endif
                    exp_q.push_back({c_EV_DONE, 12'h000});
                end
                c_K_TIMEOUT: exp_q.push_back({c_EV_ERR, 12'h000});
                c_K_MISMATCH: begin
                    exp_q.push_back(ev_wr(lock));
                    exp_q.push_back({c_EV_RD, 12'h000});
                    exp_q.push_back({c_EV_ERR, 12'h000});
                end
                default: ;
            endcase
        end
    endtask

    // Wait until every expected event has been seen and the block is idle
    task automatic drain(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !done && !error) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: actual %0d events outstanding busy=%b, required drained", name, exp_q.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation still running, required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        reset_n         = 1'b0;
        cmd_valid       = 1'b0;
        cmd_lock        = 1'b0;
        avm_waitrequest = 1'b0;
        r_force_en      = 1'b0;
        r_force_val     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_write", avm_write, 0);
        check("rst_read", avm_read, 0);
        check("rst_address", avm_address, 0);
        check("rst_writedata", avm_writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_first_edge", cmd_ready, 1);
        @(posedge clk);
        #1;

        // Single lock command, no stall: latency and one write cycle
        push_cmd(1'b1, c_K_NORMAL);
        @(negedge clk);
        check("latency_not_yet", avm_write, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("latency_write_up", avm_write, 1);
        @(posedge clk);
        #1;
        drain("drain_lock", 60);
        check("lock_write_len", last_run_len, 1);

        // Unlock with five stall cycles: write held six cycles
        avm_waitrequest = 1'b1;
        push_cmd(1'b0, c_K_NORMAL);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (avm_write) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_write_seen", seen, 1);
        repeat (5) @(posedge clk);
        #1 avm_waitrequest = 1'b0;
        drain("drain_stall", 60);
        check("stall_write_len", last_run_len, 6);

        // Fill the queue under stall, then drain in order
        avm_waitrequest = 1'b1;
        push_cmd(1'b1, c_K_NORMAL);
        push_cmd(1'b0, c_K_NORMAL);
        push_cmd(1'b1, c_K_NORMAL);
        push_cmd(1'b1, c_K_NORMAL);
        push_cmd(1'b0, c_K_NORMAL);
        @(negedge clk);
        check("queue_full_ready", cmd_ready, 0);
        check("queue_full_busy", busy, 1);
        @(posedge clk);
        #1 avm_waitrequest = 1'b0;
        push_cmd(1'b1, c_K_NORMAL);
        drain("drain_queue", 300);
`ifndef SERVO_CMD_READBACK_EN
        check("back_to_back_gap", last_gap, 1);
`endif

        // Timeout on first command, second proceeds
        avm_waitrequest = 1'b1;
        push_cmd(1'b1, c_K_TIMEOUT);
        push_cmd(1'b0, c_K_NORMAL);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (error) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("timeout_error_seen", seen, 1);
        check("timeout_write_len", last_run_len, c_TIMEOUT);
        avm_waitrequest = 1'b0;
        drain("drain_timeout", 60);
        check("timeout_next_gap", last_gap, 1);

        // Reset during a stalled write with two commands queued
        avm_waitrequest = 1'b1;
        push_cmd(1'b1, c_K_NONE);
        push_cmd(1'b0, c_K_NONE);
        push_cmd(1'b1, c_K_NONE);
        reset_n = 1'b0;
        #1;
        check("midrst_write", avm_write, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cmd_ready, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("postrst_busy", busy, 0);
        check("postrst_ready", cmd_ready, 1);

`ifdef SERVO_CMD_READBACK_EN
        // Read-back mismatch then match
        r_force_en  = 1'b1;
        r_force_val = 1'b0;
        push_cmd(1'b1, c_K_MISMATCH);
        drain("drain_rb_mismatch", 60);
        r_force_val = 1'b1;
        push_cmd(1'b1, c_K_NORMAL);
        drain("drain_rb_match", 60);
        r_force_en  = 1'b0;
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
